// File: rtl/alu_pkg.sv
// Shared ALU operation encoding, RV32I opcode/funct7 constants and the issue-entry record.
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        illegal;
  } issue_t;

  // funct3 -> ALU op for the base (funct7 = 0) encodings shared by OP and OP-IMM
  function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_ctrl = ALU_ADD;
      3'b001:  f3_ctrl = ALU_SLL;
      3'b010:  f3_ctrl = ALU_SLT;
      3'b011:  f3_ctrl = ALU_SLTU;
      3'b100:  f3_ctrl = ALU_XOR;
      3'b101:  f3_ctrl = ALU_SRL;
      3'b110:  f3_ctrl = ALU_OR;
      default: f3_ctrl = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_ctrl_decoder.sv
// Combinational decode of OP / OP-IMM / LUI into ALU control and final operands.
module alu_ctrl_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [3:0]  alu_ctrl_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [31:0] imm_s, shamt;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:20]};
  assign shamt = {27'b0, instr_i[24:20]};

  always_comb begin
    op1_o      = rs1_i;
    op2_o      = rs2_i;
    alu_ctrl_o = ALU_ADD;
    rd_o       = instr_i[11:7];
    illegal_o  = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE)                     alu_ctrl_o = f3_ctrl(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) alu_ctrl_o = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) alu_ctrl_o = ALU_SRA;
        else                                   illegal_o  = 1'b1;
      end
      OPC_OPIMM: begin
        op2_o      = imm_s;
        alu_ctrl_o = f3_ctrl(f3);
        if (f3 == 3'b001) begin
          op2_o = shamt;
          if (f7 != F7_BASE) illegal_o = 1'b1;
        end else if (f3 == 3'b101) begin
          op2_o = shamt;
          if (f7 == F7_ALT)       alu_ctrl_o = ALU_SRA;
          else if (f7 != F7_BASE) illegal_o  = 1'b1;
        end
      end
      OPC_LUI: begin
        op1_o = '0;
        op2_o = {instr_i[31:12], 12'b0};
      end
      default: illegal_o = 1'b1;
    endcase
    // Illegal entries still flow downstream but carry no operand data
    if (illegal_o) begin
      op1_o      = '0;
      op2_o      = '0;
      alu_ctrl_o = ALU_ADD;
      rd_o       = '0;
    end
  end
endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage: decode, then a 2-entry skid buffer (M drives outputs, S absorbs overflow).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [3:0]      out_alu_ctrl,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);
  issue_t dec, m_q, m_d, s_q, s_d;
  logic   m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic   in_fire, out_fire;

  alu_ctrl_decoder u_dec (
    .instr_i   (in_instr),
    .rs1_i     (in_rs1_data),
    .rs2_i     (in_rs2_data),
    .op1_o     (dec.op1),
    .op2_o     (dec.op2),
    .alu_ctrl_o(dec.ctrl),
    .rd_o      (dec.rd),
    .illegal_o (dec.illegal)
  );

  assign in_fire  = in_valid & ~s_vld_q;
  assign out_fire = m_vld_q & out_ready;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (s_vld_q) begin
      // FULL: in_ready is low, only the drain of M matters
      if (out_ready) begin
        m_d     = s_q;
        s_vld_d = 1'b0;
      end
    end else if (m_vld_q) begin
      if (in_fire && out_fire) m_d = dec;
      else if (out_fire)       m_vld_d = 1'b0;
      else if (in_fire) begin
        s_d     = dec;
        s_vld_d = 1'b1;
      end
    end else if (in_valid) begin
      m_d     = dec;
      m_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  assign in_ready     = ~s_vld_q;
  assign out_valid    = m_vld_q;
  assign out_op1      = m_q.op1;
  assign out_op2      = m_q.op2;
  assign out_alu_ctrl = m_q.ctrl;
  assign out_rd       = m_q.rd;
  assign out_illegal  = m_q.illegal;
endmodule
